// File: rtl/cache_access_driver.sv
// -----------------------------------------------------------------------------
// cache_access_driver
//
// Request-side traffic generator for a single-ported cache. One run walks
// count addresses starting at base_addr with a fixed stride, issuing one access
// per cycle. The run is a read pass, a write pass, or a write pass followed
// immediately by a read pass over the same addresses. The cache answers every
// request one cycle later. Answers to run accesses are counted as hits and
// misses. Answers to idle-cycle accesses are ignored.
//
// Optional feature (compile-time macro CACHE_DRV_DATA_CHECK_EN):
//   When defined, each counted read-pass hit has its read data compared with
//   the pattern that the write pass stores at that address. Each mismatch
//   increments err_cnt. When undefined, err_cnt is tied to zero.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   start                 begin a run (sampled in IDLE only)
//   base_addr/stride      walk start address / zero-extended increment
//   count                 accesses per pass
//   mode                  00 read, 01 write, 10 write then read, 11 read
//   c_addr/c_wr_data/c_wr_en   registered request to the cache
//   c_rd_data/c_hit/c_miss     cache response, one cycle after the request
//   busy                  high while in RUN or DRAIN
//   done                  one-cycle pulse; all counters are final
//   hit_cnt/miss_cnt      saturating result counters for the current run
//   err_cnt               saturating read-data mismatch count (macro only)
// -----------------------------------------------------------------------------
module cache_access_driver #(
  parameter logic [31:0] IDLE_ADDR  = 32'hFFFF_FFF0,
  parameter logic [7:0]  WDATA_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] stride,
  input  logic [15:0] count,
  input  logic [1:0]  mode,
  output logic [31:0] c_addr,
  output logic [7:0]  c_wr_data,
  output logic        c_wr_en,
  input  logic [7:0]  c_rd_data,
  input  logic        c_hit,
  input  logic        c_miss,
  output logic        busy,
  output logic        done,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [15:0] stride_q;
  logic [15:0] count_q;
  logic [1:0]  mode_q;
  logic [15:0] idx;       // index of the access currently on c_addr
  logic        pass_wr;   // current pass is the write pass
  logic        res_flag;  // the response in this cycle belongs to a run access

  logic [31:0] next_addr;
  logic        last_acc;
  logic        two_pass;
  logic        start_wr;
  logic        start_acc;

  // The running address is accumulated rather than computed as base+i*stride,
  // which keeps a multiplier off the request path.
  assign next_addr = c_addr + {16'd0, stride_q};
  assign last_acc  = (idx == count_q - 16'd1);
  assign two_pass  = (mode_q == 2'b10);
  assign start_wr  = (mode == 2'b01) || (mode == 2'b10);
  assign start_acc = (state == S_IDLE) && start;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // behaviour between the counters and the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      count_q   <= '0;
      mode_q    <= '0;
      idx       <= '0;
      pass_wr   <= 1'b0;
      res_flag  <= 1'b0;
      c_addr    <= IDLE_ADDR;
      c_wr_data <= '0;
      c_wr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      done     <= 1'b0;
      res_flag <= (state == S_RUN);

      if (res_flag) begin
        if (c_hit && (hit_cnt != '1))
          hit_cnt <= hit_cnt + 32'd1;
        if (c_miss && (miss_cnt != '1))
          miss_cnt <= miss_cnt + 32'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            stride_q <= stride;
            count_q  <= count;
            mode_q   <= mode;
            idx      <= '0;
            pass_wr  <= start_wr;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            busy     <= 1'b1;
            if (count == 16'd0) begin
              state <= S_DRAIN;
            end else begin
              state     <= S_RUN;
              c_addr    <= base_addr;
              c_wr_en   <= start_wr;
              c_wr_data <= start_wr ? (base_addr[7:0] ^ WDATA_SEED) : 8'd0;
            end
          end
        end

        S_RUN: begin
          if (last_acc) begin
            if (two_pass && pass_wr) begin
              // Turn straight around into the read pass, no idle cycle.
              pass_wr   <= 1'b0;
              idx       <= '0;
              c_addr    <= base_q;
              c_wr_en   <= 1'b0;
              c_wr_data <= '0;
            end else begin
              state     <= S_DRAIN;
              c_addr    <= IDLE_ADDR;
              c_wr_en   <= 1'b0;
              c_wr_data <= '0;
            end
          end else begin
            idx       <= idx + 16'd1;
            c_addr    <= next_addr;
            c_wr_en   <= pass_wr;
            c_wr_data <= pass_wr ? (next_addr[7:0] ^ WDATA_SEED) : 8'd0;
          end
        end

        // The final run response is counted on the edge leaving DRAIN.
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_DRV_DATA_CHECK_EN
  logic [31:0] res_addr;  // address of the request whose response is arriving
  logic        res_rd;    // that request was a read-pass access
  logic [7:0]  exp_data;
  logic        unused_res_addr;

  assign exp_data        = res_addr[7:0] ^ WDATA_SEED;
  assign unused_res_addr = ^res_addr[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_addr <= '0;
      res_rd   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      res_addr <= c_addr;
      res_rd   <= (state == S_RUN) && !pass_wr;
      if (start_acc)
        err_cnt <= '0;
      else if (res_flag && res_rd && c_hit && (c_rd_data != exp_data) &&
               (err_cnt != '1))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_rd_data;

  assign unused_rd_data = ^{c_rd_data, start_acc};
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_cache_access_driver.sv
// -----------------------------------------------------------------------------
// tb_cache_access_driver
//
// Drives cache_access_driver against a small behavioural cache (256 B,
// 16 B blocks, 4 sets x 4 ways, LRU, write-allocate, one-cycle response).
// A vector table gives each run's settings and expected counters. The
// per-cycle request stream and busy/done timing are derived from the run
// settings. Expected end-of-run counters go into a scoreboard queue at start
// and are popped when the DUT pulses done.
// -----------------------------------------------------------------------------
module tb_cache_access_driver;

  localparam logic [31:0] IDLE_ADDR  = 32'hFFFF_FFF0;
  localparam logic [7:0]  WDATA_SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] stride;
  logic [15:0] count;
  logic [1:0]  mode;
  logic [31:0] c_addr;
  logic [7:0]  c_wr_data;
  logic        c_wr_en;
  logic [7:0]  c_rd_data;
  logic        c_hit;
  logic        c_miss;
  logic        busy;
  logic        done;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  cache_access_driver #(.IDLE_ADDR(IDLE_ADDR), .WDATA_SEED(WDATA_SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .stride(stride), .count(count), .mode(mode), .c_addr(c_addr),
    .c_wr_data(c_wr_data), .c_wr_en(c_wr_en), .c_rd_data(c_rd_data),
    .c_hit(c_hit), .c_miss(c_miss), .busy(busy), .done(done),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural cache ----------------
  logic        vld_q [4][4];
  logic [25:0] tag_q [4][4];
  int unsigned age_q [4][4];
  logic [7:0]  mem_q [256];
  int unsigned tick;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 4; w++) begin
          vld_q[s][w] <= 1'b0;
          tag_q[s][w] <= '0;
          age_q[s][w] <= 0;
        end
      for (int b = 0; b < 256; b++) mem_q[b] <= 8'h00;
      tick      <= 1;
      c_hit     <= 1'b0;
      c_miss    <= 1'b0;
      c_rd_data <= 8'h00;
    end else begin
      automatic int          set = int'(c_addr[5:4]);
      automatic logic [25:0] tg  = c_addr[31:6];
      automatic int          way = -1;
      automatic int          vic = 0;
      for (int w = 0; w < 4; w++)
        if (vld_q[set][w] && tag_q[set][w] == tg) way = w;
      c_hit  <= (way >= 0);
      c_miss <= (way < 0);
      if (way < 0) begin
        for (int w = 3; w >= 0; w--)
          if (!vld_q[set][w]) vic = w;
        if (vld_q[set][0] && vld_q[set][1] && vld_q[set][2] && vld_q[set][3])
          for (int w = 1; w < 4; w++)
            if (age_q[set][w] < age_q[set][vic]) vic = w;
        way = vic;
        vld_q[set][way] <= 1'b1;
        tag_q[set][way] <= tg;
      end
      age_q[set][way] <= tick;
      tick            <= tick + 1;
      if (c_wr_en) mem_q[c_addr[7:0]] <= c_wr_data;
      c_rd_data <= c_wr_en ? c_wr_data : mem_q[c_addr[7:0]];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] base;
    logic [15:0] stride;
    logic [15:0] count;
    int          hit;
    int          miss;
  } vec_t;

  typedef struct {
    int hit;
    int miss;
  } exp_t;

  exp_t sb[$];

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("rst_c_addr", c_addr, IDLE_ADDR);
    check("rst_c_wr_en", {31'd0, c_wr_en}, 0);
    check("rst_c_wr_data", {24'd0, c_wr_data}, 0);
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_counters", hit_cnt | miss_cnt | {16'd0, err_cnt}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          n;
    int          accs;
    int          dcyc;
    logic [31:0] ea;
    logic        ew;
    exp_t        e;
    exp_t        got;
    do_reset();
    n    = int'(v.count);
    accs = (v.mode == 2'b10) ? 2 * n : n;
    dcyc = accs + 2;
    e.hit  = v.hit;
    e.miss = v.miss;
    sb.push_back(e);

    @(negedge clk);
    base_addr = v.base;
    stride    = v.stride;
    count     = v.count;
    mode      = v.mode;
    start     = 1'b1;
    @(posedge clk);

    for (int k = 1; k <= dcyc + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble inputs: the run must use the values latched at start.
        start     = 1'b0;
        base_addr = $urandom;
        stride    = 16'($urandom);
        count     = 16'($urandom);
        mode      = 2'($urandom);
      end
      if (k <= accs) begin
        ea = v.base + 32'((k - 1) % n) * {16'd0, v.stride};
        ew = (v.mode == 2'b01) || (v.mode == 2'b10 && k <= n);
      end else begin
        ea = IDLE_ADDR;
        ew = 1'b0;
      end
      check($sformatf("v%0d_c%0d_addr", id, k), c_addr, ea);
      check($sformatf("v%0d_c%0d_wr_en", id, k), {31'd0, c_wr_en}, {31'd0, ew});
      if (ew)
        check($sformatf("v%0d_c%0d_wdata", id, k), {24'd0, c_wr_data},
              {24'd0, ea[7:0] ^ WDATA_SEED});
      check($sformatf("v%0d_c%0d_busy", id, k), {31'd0, busy},
            {31'd0, (k < dcyc)});
      check($sformatf("v%0d_c%0d_done", id, k), {31'd0, done},
            {31'd0, (k == dcyc)});
      if (done && sb.size() != 0) begin
        got = sb.pop_front();
        check($sformatf("v%0d_hit_cnt", id), hit_cnt, got.hit);
        check($sformatf("v%0d_miss_cnt", id), miss_cnt, got.miss);
        check($sformatf("v%0d_err_cnt", id), {16'd0, err_cnt}, 0);
      end
      // start during DONE must not launch a new run (busy stays low after).
      if (k == dcyc) start = 1'b1;
      if (k == dcyc + 1) start = 1'b0;
    end
    if (sb.size() != 0) begin
      check($sformatf("v%0d_done_seen", id), 0, 1);
      sb.delete();
    end
  endtask

  vec_t vecs[8];

  initial begin
    int seen_done;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    stride    = '0;
    count     = '0;
    mode      = '0;

    vecs[0] = '{2'b00, 32'h0000_0000, 16'd1,  16'd16, 15, 1};
    vecs[1] = '{2'b00, 32'h0000_0000, 16'd64, 16'd8,  0,  8};
    vecs[2] = '{2'b10, 32'h0000_0100, 16'd1,  16'd16, 31, 1};
    vecs[3] = '{2'b00, 32'h0000_0000, 16'd1,  16'd0,  0,  0};
    vecs[4] = '{2'b10, 32'h0000_0000, 16'd1,  16'd0,  0,  0};
    vecs[5] = '{2'b00, 32'hFFFF_FFFE, 16'd1,  16'd4,  3,  1};
    vecs[6] = '{2'b01, 32'h0000_0200, 16'd16, 16'd4,  0,  4};
    vecs[7] = '{2'b11, 32'h0000_0040, 16'd1,  16'd16, 15, 1};

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in RUN cycle 3 of a 16-access write run, after a stray start.
    do_reset();
    @(negedge clk);
    base_addr = 32'h0000_1000;
    stride    = 16'd4;
    count     = 16'd16;
    mode      = 2'b01;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_pre_addr", c_addr, 32'h0000_1008);
    check("abort_pre_wr_en", {31'd0, c_wr_en}, 1);
    check("abort_pre_miss", miss_cnt, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_wr_en", {31'd0, c_wr_en}, 0);
    check("abort_addr", c_addr, IDLE_ADDR);
    check("abort_counters", hit_cnt | miss_cnt | {16'd0, err_cnt}, 0);
    @(negedge clk);
    reset     = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy || c_wr_en) seen_done++;
    end
    check("abort_quiet_after", seen_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
